// File: rtl/fetch_line_buffer_pkg.sv
// Shared types and constants for the instruction-fetch line buffer.
// Sysbus tag fields mirror the sysbus read/memory encodings.
package fetch_line_buffer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StFill,
      StServe,
      StCheck
   } fetch_state_e;

   localparam int unsigned LineBytes = 64;
   localparam int unsigned LineBits  = LineBytes * 8;

   localparam logic       SysbusRead   = 1'b1;
   localparam logic [3:0] SysbusMemory = 4'b0001;
   localparam logic [12:0] ReadTag     = {SysbusRead, SysbusMemory, 8'h00};

   function automatic logic [63:0] line_base(input logic [63:0] addr);
      return addr & ~(64'(LineBytes) - 64'd1);
   endfunction

endpackage

// File: rtl/fetch_line_buffer_line_buffer.sv
// One 64-byte line: 64-bit beat write port, 32-bit word read port.
// The read port sees a beat written in the same cycle.
module fetch_line_buffer_line_buffer
   import fetch_line_buffer_pkg::*;
(
   input  logic        clk,
   input  logic        wr_en,
   input  logic [2:0]  wr_beat,
   input  logic [63:0] wr_data,
   input  logic [3:0]  rd_word,
   output logic [31:0] rd_data
);

   logic [LineBits-1:0] line_q;
   logic [LineBits-1:0] line_d;

   always_comb begin
      line_d = line_q;
      if (wr_en) begin
         line_d[{wr_beat, 6'd0} +: 64] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      line_q <= line_d;
   end

   // Reading the next-state image lets the final beat and the first insn share a cycle.
   always_comb begin
      rd_data = line_d[{rd_word, 5'd0} +: 32];
   end

endmodule

// File: rtl/fetch_line_buffer.sv
// Instruction-fetch front end: fetches 64-byte lines over sysbus and serves
// 32-bit instructions to decode, handling line crossing and redirects.
module fetch_line_buffer
   import fetch_line_buffer_pkg::*;
#(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned LINE_BEATS     = 8,
   parameter int unsigned INSN_WIDTH     = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [63:0]               entry_pc,
   output logic                      reqcyc,
   input  logic                      reqack,
   output logic [63:0]               req,
   output logic [BUS_TAG_WIDTH-1:0]  reqtag,
   input  logic                      respcyc,
   output logic                      respack,
   input  logic [BUS_DATA_WIDTH-1:0] resp,
   input  logic [BUS_TAG_WIDTH-1:0]  resptag,
   output logic                      insn_valid,
   input  logic                      insn_ready,
   output logic [INSN_WIDTH-1:0]     insn,
   output logic [63:0]               insn_pc,
   input  logic                      redirect_valid,
   input  logic [63:0]               redirect_pc
);

   localparam logic [2:0] LastBeat = 3'(LINE_BEATS - 1);

   fetch_state_e state_q, state_d;
   logic [63:0]  pc_q, pc_d;
   logic [63:0]  pend_pc_q, pend_pc_d;
   logic         pend_valid_q, pend_valid_d;
   logic         line_valid_q, line_valid_d;
   logic [57:0]  line_tag_q, line_tag_d;
   logic [2:0]   beat_cnt_q, beat_cnt_d;

   logic                     reqcyc_q, reqcyc_d;
   logic [63:0]              req_q, req_d;
   logic [BUS_TAG_WIDTH-1:0] reqtag_q, reqtag_d;
   logic                     insn_valid_q, insn_valid_d;
   logic [INSN_WIDTH-1:0]    insn_q, insn_d;
   logic [63:0]              insn_pc_q, insn_pc_d;

   logic [63:0] redir_pc;
   logic [63:0] check_pc;
   logic        lb_we;
   logic [31:0] lb_rd_data;
   logic        unused_inputs;

   assign redir_pc      = {redirect_pc[63:2], 2'b00};
   assign respack       = (state_q == StFill) & respcyc;
   assign unused_inputs = ^{resptag, entry_pc[1:0], redirect_pc[1:0]};

   fetch_line_buffer_line_buffer u_line_buffer (
      .clk     (clk),
      .wr_en   (lb_we),
      .wr_beat (beat_cnt_q),
      .wr_data (resp),
      .rd_word (pc_d[5:2]),
      .rd_data (lb_rd_data)
   );

   // Control: state, pc, pending redirect and line bookkeeping.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pend_pc_d    = pend_pc_q;
      pend_valid_d = pend_valid_q;
      line_valid_d = line_valid_q;
      line_tag_d   = line_tag_q;
      beat_cnt_d   = beat_cnt_q;
      lb_we        = 1'b0;
      check_pc     = redirect_valid ? redir_pc : pend_pc_q;

      unique case (state_q)
         StIdle: begin
            state_d = StReq;
            if (redirect_valid) begin
               pc_d = redir_pc;
            end
         end
         StReq: begin
            // An issued request is never withdrawn; redirects wait for the fill.
            if (redirect_valid) begin
               pend_pc_d    = redir_pc;
               pend_valid_d = 1'b1;
            end
            if (reqack) begin
               state_d    = StFill;
               beat_cnt_d = 3'd0;
            end
         end
         StFill: begin
            if (redirect_valid) begin
               pend_pc_d    = redir_pc;
               pend_valid_d = 1'b1;
            end
            if (respcyc) begin
               lb_we      = 1'b1;
               beat_cnt_d = beat_cnt_q + 3'd1;
               if (beat_cnt_q == LastBeat) begin
                  line_tag_d   = pc_q[63:6];
                  line_valid_d = 1'b1;
                  state_d      = pend_valid_d ? StCheck : StServe;
               end
            end
         end
         StServe: begin
            if (redirect_valid) begin
               pc_d = redir_pc;
               if (redir_pc[63:6] != line_tag_q) begin
                  state_d = StReq;
               end
            end else if (insn_ready) begin
               pc_d = pc_q + 64'd4;
               if (pc_q[5:2] == 4'hf) begin
                  state_d      = StReq;
                  line_valid_d = 1'b0;
               end
            end
         end
         StCheck: begin
            pc_d         = check_pc;
            pend_valid_d = 1'b0;
            if (line_valid_q && (check_pc[63:6] == line_tag_q)) begin
               state_d = StServe;
            end else begin
               state_d = StReq;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Registered bus and decode outputs, derived from the next state.
   always_comb begin
      reqcyc_d     = (state_d == StReq);
      req_d        = req_q;
      reqtag_d     = reqtag_q;
      insn_valid_d = (state_d == StServe);
      insn_d       = insn_q;
      insn_pc_d    = insn_pc_q;
      if (state_d == StReq) begin
         req_d    = line_base(pc_d);
         reqtag_d = ReadTag;
      end
      if (state_d == StServe) begin
         insn_d    = lb_rd_data;
         insn_pc_d = pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         pc_q         <= {entry_pc[63:2], 2'b00};
         pend_pc_q    <= '0;
         pend_valid_q <= 1'b0;
         line_valid_q <= 1'b0;
         line_tag_q   <= '0;
         beat_cnt_q   <= 3'd0;
         reqcyc_q     <= 1'b0;
         req_q        <= '0;
         reqtag_q     <= '0;
         insn_valid_q <= 1'b0;
         insn_q       <= '0;
         insn_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pend_pc_q    <= pend_pc_d;
         pend_valid_q <= pend_valid_d;
         line_valid_q <= line_valid_d;
         line_tag_q   <= line_tag_d;
         beat_cnt_q   <= beat_cnt_d;
         reqcyc_q     <= reqcyc_d;
         req_q        <= req_d;
         reqtag_q     <= reqtag_d;
         insn_valid_q <= insn_valid_d;
         insn_q       <= insn_d;
         insn_pc_q    <= insn_pc_d;
      end
   end

   assign reqcyc     = reqcyc_q;
   assign req        = req_q;
   assign reqtag     = reqtag_q;
   // A redirect outranks decode's ready, so the current insn is withdrawn.
   assign insn_valid = insn_valid_q & ~redirect_valid;
   assign insn       = insn_q;
   assign insn_pc    = insn_pc_q;

endmodule

// File: doc/fetch_line_buffer.md
Name: fetch_line_buffer

Overview:
- Instruction-fetch front end on channel 0 of the memory arbiter.
- Issues 64-byte line read requests on the sysbus-style handshake (reqcyc/reqack, respcyc/respack) and collects 8 x 64-bit response beats into a line buffer.
- Serves 32-bit instructions to decode over a valid/ready interface.
- Handles sequential line crossing and PC redirects (branch/jump) from downstream.

Parameters:
- BUS_DATA_WIDTH, 64, request/response beat width
- BUS_TAG_WIDTH, 13, request/response tag width
- LINE_BEATS, 8, beats per cache line (line = 512 bits, 64 bytes)
- INSN_WIDTH, 32, instruction width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- entry_pc  in  64  first fetch PC, sampled while reset is high
- reqcyc  out  1  line request valid, to arbiter reqcyc0
- reqack  in  1  request accepted, from arbiter reqack0
- req  out  64  line-aligned request address
- reqtag  out  13  request tag
- respcyc  in  1  response beat valid
- respack  out  1  response beat accepted
- resp  in  64  response beat data
- resptag  in  13  response tag (ignored)
- insn_valid  out  1  instruction available
- insn_ready  in  1  decode accepts instruction
- insn  out  32  instruction word
- insn_pc  out  64  PC of insn
- redirect_valid  in  1  one-cycle redirect pulse
- redirect_pc  in  64  redirect target; bits [1:0] forced to 0

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values:
  - state=IDLE; reqcyc=0, respack=0, insn_valid=0.
  - req=0, reqtag=0, insn=0, insn_pc=0.
  - pc={entry_pc[63:2],2'b0}; line_valid=0; pend_valid=0; beat_cnt=0.
- Reset mid-operation: abandons any request or fill immediately; the arbiter must be reset in the same cycle.
- States:
  - IDLE: next cycle -> REQ.
  - REQ:
    - reqcyc=1, req={pc[63:6],6'b0}, reqtag={`SYSBUS_READ,`SYSBUS_MEMORY,8'h00}.
    - req and reqtag are stable while reqcyc=1.
    - reqcyc stays high until reqack=1; on reqack -> FILL, beat_cnt=0. reqcyc is 0 in FILL.
  - FILL:
    - respack=respcyc (combinational, same cycle).
    - Each accepted beat writes line[64*beat_cnt +: 64]=resp, then beat_cnt++.
    - On the beat with beat_cnt==7: line_tag=pc[63:6], line_valid=1, -> SERVE (or -> CHECK if pend_valid).
  - SERVE:
    - insn_valid=1, insn=line[32*pc[5:2] +: 32] (little-endian within the line), insn_pc=pc.
    - On insn_valid&insn_ready: pc+=4. If pc[5:2]==15 (line crossing) -> REQ, line_valid=0.
  - CHECK (single cycle):
    - pc=pend_pc, pend_valid=0.
    - If line_valid and pend_pc[63:6]==line_tag -> SERVE; else -> REQ.
- Fetch latency: reset deassert -> IDLE -> REQ is 1 cycle; first insn_valid comes the cycle after the 8th beat handshake.
- Redirect rules:
  - In SERVE: redirect_valid has priority over insn_ready. insn_valid is forced 0 that cycle; pc=redirect_pc.
    - Same line (redirect_pc[63:6]==line_tag): stay SERVE, new insn appears next cycle.
    - Otherwise: -> REQ.
  - In REQ or FILL: a request in flight is never withdrawn. Store pend_pc=redirect_pc, pend_valid=1; a later redirect overwrites.
    - The fill completes and line_valid/line_tag are updated with the fetched line; then -> CHECK.
  - In IDLE: pc=redirect_pc, no pend.
- Boundaries:
  - Redirect in the same cycle as reqack: recorded as pend; FILL proceeds.
  - Redirect in the same cycle as the final beat: pend wins, -> CHECK.
  - pc wrap at 2^64: modulo, no special handling.
  - respcyc outside FILL: ignored, respack=0.
- Width rules: beat_cnt is 3 bits; word index is pc[5:2] (4 bits); line_tag is 58 bits.

Decomposition:
- Shared package (sysbus_pkg): state enum {IDLE,REQ,FILL,SERVE,CHECK}, LINE_BYTES=64, the read-tag constant built from Sysbus.defs.
- Sub-module line_buffer: 512-bit register with beat write port (64-bit, 3-bit index) and word read port (32-bit, 4-bit index).

Test Plan:
- Reset with entry_pc=0x1000, memory line at 0x1000 holds words 0x00000013+i (i=0..15), insn_ready=1 -> req=0x1000 with reqtag read; after 8 beats, insns 0x13..0x22 at pcs 0x1000..0x103C, one per cycle.
- Sequential crossing: continue past 0x103C -> new reqcyc with req=0x1040; no insn_valid during the refetch; first insn at pc 0x1040.
- Arbiter delays reqack 5 cycles and respcyc with 2-cycle gaps -> req/reqtag stable throughout, respack only coincident with respcyc, 8 beats captured in order.
- Redirect to 0x1020 while serving 0x1008 -> no refetch; next insn is at pc 0x1020 with word 8 of the line.
- Redirect to 0x2004 at the 3rd beat of FILL, then to 0x3008 at the 5th beat -> fill of the current line completes; the next request is req=0x3000; first insn at pc 0x3008.
- Reset asserted during FILL beat 4 -> next cycle all outputs at reset values; after release, fetch restarts at entry_pc.
